data_mem_responder: RTL and testbench

Multi-cycle data-memory responder that replaces the single-cycle data memory on the processor's load/store path. Accepts one word request at a time over a valid/ready request channel, inserts a programmable number of wait states, commits byte-masked writes or fetches read data, then returns a response over a valid/ready response channel. Sits between the processor core's load/store unit and a word-organised SRAM array. Lets the core be tested against non-ideal memory latency.

---
 rtl/mem_resp_pkg.sv | 21 ++
 rtl/mem_array.sv | 41 ++++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// ============================================================================
// Module  : mem_resp_pkg
// Brief   : Shared types and widths for the multi-cycle data-memory responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WAIT_W = 4;
    localparam int BE_W   = 4;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module  : mem_array
// Brief   : Word-organised 32-bit array, synchronous byte-masked write,
//           combinational read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [BE_W-1:0]       i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [31:0] r_mem [DEPTH];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module  : data_mem_responder
// Brief   : One-outstanding valid/ready data-memory responder with
//           programmable wait states in front of a byte-masked word array.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [31:0]     resp_rdata,
    output logic            resp_err
);

    localparam logic [WAIT_W-1:0] c_wait_init = WAIT_W'(WAIT_CYCLES);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_accept;
    logic                  r_write;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [BE_W-1:0]       r_be;
    logic [WAIT_W-1:0]     r_cnt;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic                  w_err;
    logic                  w_commit;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [31:0]           w_mem_rdata;

    // Misaligned, or any byte-address bit above the array's reach.
    assign w_err       = (r_addr[1:0] != 2'b00) || ((r_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_commit    = (r_state == WAIT) && (r_cnt == '0);
    assign w_word_addr = r_addr[ADDR_WIDTH+1:2];
    assign w_we        = w_commit && !w_err && r_write && rst_n;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_nxt = WAIT;
                    w_accept    = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_cnt   <= c_wait_init;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - WAIT_W'(1);
            end
            if (w_commit) begin
                r_rdata <= (!w_err && !r_write) ? w_mem_rdata : 32'd0;
                r_err   <= w_err;
            end
        end
    end

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_word_addr),
        .i_be    (r_be),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign req_ready  = rst_n && (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed self-checking bench for data_mem_responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int ADDR_WIDTH  = 10;
    localparam int WAIT_CYCLES = 2;
    localparam int EXP_LAT     = WAIT_CYCLES + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until the accepting edge has passed.
    task automatic send_req(input string tag, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        while (!acc && n < 20) begin
            acc = req_ready;
            tick();
            n++;
        end
        req_valid = 1'b0;
        check_val({tag, "_accept"}, {31'd0, acc}, 32'd1);
    endtask

    // Count edges from acceptance to resp_valid; consume if resp_ready is high.
    task automatic wait_resp(output logic [31:0] rd, output logic e, output int lat);
        lat = 0;
        while (!resp_valid && lat < 50) begin
            tick();
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        if (resp_ready) tick();
    endtask

    task automatic txn(input string tag, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        int          lat;
        send_req(tag, wr, a, wd, be);
        wait_resp(rd, e, lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(EXP_LAT));
        check_val({tag, "_rdata"}, rd, exp_rd);
        check_val({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    initial begin
        logic [31:0] rd0;
        logic        e0;
        int          lat0;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_be     = '0;
        resp_ready = 1'b1;

        // Reset then idle
        tick();
        check_val("rst_ready_low_0", {31'd0, req_ready}, 32'd0);
        tick();
        check_val("rst_ready_low_1", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("idle_ready", {31'd0, req_ready}, 32'd1);
        check_val("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_val("idle_rdata", resp_rdata, 32'd0);
        check_val("idle_err", {31'd0, resp_err}, 32'd0);

        // Store then load
        txn("st_dead", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        txn("ld_dead", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte merge
        txn("st_merge", 1'b1, 32'h10, 32'h00001234, 4'b0011, 32'h0, 1'b0);
        txn("ld_merge", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0);

        // Zero-enable store changes nothing
        txn("st_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        txn("ld_be0", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0);

        // Errors: misaligned and out of range must not touch the array
        txn("st_w0", 1'b1, 32'h0, 32'h0, 4'hF, 32'h0, 1'b0);
        txn("ld_mis", 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1);
        txn("st_mis", 1'b1, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
        txn("st_oor", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        txn("ld_w0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        txn("ld_chk10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0);

        // Backpressure with an ignored store pulse during the stall
        resp_ready = 1'b0;
        send_req("bp", 1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp(rd0, e0, lat0);
        check_val("bp_lat", 32'(lat0), 32'(EXP_LAT));
        for (int i = 0; i < 5; i++) begin
            req_valid = (i % 2 == 0);
            req_write = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'h0;
            req_be    = 4'hF;
            tick();
            check_val("bp_valid", {31'd0, resp_valid}, 32'd1);
            check_val("bp_rdata", resp_rdata, 32'hDEAD1234);
            check_val("bp_err", {31'd0, resp_err}, 32'd0);
            check_val("bp_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        check_val("bp_done_valid", {31'd0, resp_valid}, 32'd0);
        check_val("bp_done_ready", {31'd0, req_ready}, 32'd1);
        txn("bp_ld", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD1234, 1'b0);

        // Reset before commit abandons the store
        txn("st_ones", 1'b1, 32'h20, 32'h11111111, 4'hF, 32'h0, 1'b0);
        send_req("st_a5", 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
        rst_n = 1'b0;
        tick();
        tick();
        check_val("midrst_ready", {31'd0, req_ready}, 32'd0);
        check_val("midrst_valid", {31'd0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        check_val("midrst_idle", {31'd0, req_ready}, 32'd1);
        txn("ld_ones", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
